// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if / dmem_bus_if
//   Bus bundles used by dmem_arbiter.
//
//   dmem_arbiter_if : one requesting master's transfer port.
//     req, we, addr, wdata   master -> arbiter  (request, 1=write, byte address, write data)
//     gnt                    arbiter -> master  (transfer accepted this cycle)
//     rvalid, rdata          arbiter -> master  (read data, one cycle after a granted read)
//     modport master : the requesting side
//     modport slave  : the arbiter side
//
//   dmem_bus_if : connection to the single-port data memory (64 x 32b).
//     a, wd, we              arbiter -> memory  (address, write data, write enable)
//     rd                     memory  -> arbiter (combinational read data of a)
//     modport master : the arbiter side
//     modport slave  : the memory side
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dmem_bus_if;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;

  modport master (output a, wd, we, input rd);
  modport slave  (input a, wd, we, output rd);
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-master arbiter in front of the single-port data memory. Master 0 is the
//   CPU load/store port, master 1 the debug/DMA loader. One transfer is granted
//   per cycle; a master may keep ownership for up to BURST_MAX consecutive
//   transfers while the other is waiting, then ownership passes over. Read data
//   is registered and returned to the granted master one cycle later.
//
// Parameters
//   BURST_MAX  max consecutive transfers for one master while the other waits (>=1)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset
//   m0     dmem_arbiter_if.slave  master 0 (CPU)
//   m1     dmem_arbiter_if.slave  master 1 (debug/DMA)
//   mem    dmem_bus_if.master     data memory port
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  m0,
  dmem_arbiter_if.slave  m1,
  dmem_bus_if.master     mem
);

  localparam int             CW      = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(BURST_MAX);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lru, lru_nxt;
  logic          gnt0, gnt1;
  logic          sat;
  logic          rvalid0, rvalid1;
  logic [31:0]   rdata0, rdata1;

  // cnt never exceeds CNT_MAX, so equality is the same as "not below the limit"
  assign sat = (cnt == CNT_MAX);

  // State register: owner, burst length and last-served master
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      lru   <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lru   <= lru_nxt;
    end
  end

  // Next-state logic driven by this cycle's grant decision
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lru_nxt   = lru;
    if (gnt0) begin
      if (state == OWN0) begin
        cnt_nxt = sat ? cnt : cnt + CNT_ONE;
      end else begin
        state_nxt = OWN0;
        cnt_nxt   = CNT_ONE;
        lru_nxt   = 1'b0;
      end
    end else if (gnt1) begin
      if (state == OWN1) begin
        cnt_nxt = sat ? cnt : cnt + CNT_ONE;
      end else begin
        state_nxt = OWN1;
        cnt_nxt   = CNT_ONE;
        lru_nxt   = 1'b1;
      end
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Grant decision and memory drive. The owner keeps the bus until its burst
  // saturates with the other master waiting; a saturated owner with an idle
  // rival keeps going. From IDLE a tie goes to the master not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      IDLE: begin
        if (m0.req && m1.req) begin
          gnt0 = lru;
          gnt1 = ~lru;
        end else begin
          gnt0 = m0.req;
          gnt1 = m1.req;
        end
      end
      OWN0: begin
        if (m0.req && (!sat || !m1.req)) gnt0 = 1'b1;
        else                             gnt1 = m1.req;
      end
      OWN1: begin
        if (m1.req && (!sat || !m0.req)) gnt1 = 1'b1;
        else                             gnt0 = m0.req;
      end
      default: ;
    endcase

    mem.a  = '0;
    mem.wd = '0;
    mem.we = 1'b0;
    if (gnt0) begin
      mem.a  = m0.addr;
      mem.wd = m0.wdata;
      mem.we = m0.we;
    end else if (gnt1) begin
      mem.a  = m1.addr;
      mem.wd = m1.wdata;
      mem.we = m1.we;
    end
  end

  // Read return: capture combinational memory data on a granted read. Reset
  // drops any response in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~m0.we;
      rvalid1 <= gnt1 & ~m1.we;
      if (gnt0 && !m0.we) rdata0 <= mem.rd;
      if (gnt1 && !m1.we) rdata1 <= mem.rd;
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rdata0;
  assign m1.rdata  = rdata1;

endmodule
